// File: rtl/gpu_raster_pkg.sv
// Shared raster definitions: screen geometry, coordinate/address widths,
// line FSM states and the framebuffer address helper.
package gpu_raster_pkg;

   localparam int unsigned SCREEN_WIDTH  = 640;
   localparam int unsigned SCREEN_HEIGHT = 480;
   localparam int unsigned COORD_W       = 12;
   localparam int unsigned ADDR_W        = 19;
   localparam int unsigned ERR_W         = COORD_W + 2;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PLOT,
      WRITE,
      STEP,
      DONE
   } state_e;

   // Row-major address; off-screen coordinates simply wrap into ADDR_W bits.
   function automatic logic [ADDR_W-1:0] pix_addr(input logic signed [COORD_W-1:0] x,
                                                  input logic signed [COORD_W-1:0] y);
      logic [31:0] sum;
      sum = 32'(y) * 32'(SCREEN_WIDTH) + 32'(x);
      return sum[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/line_raster_step.sv
// Combinational Bresenham step: advances (x, y, err) by one pixel along the line.
module line_raster_step
   import gpu_raster_pkg::*;
(
   input  logic signed [COORD_W-1:0] i_x,
   input  logic signed [COORD_W-1:0] i_y,
   input  logic signed [ERR_W-1:0]   i_err,
   input  logic signed [ERR_W-1:0]   i_dx,
   input  logic signed [ERR_W-1:0]   i_dy,
   input  logic                      i_sx_neg,
   input  logic                      i_sy_neg,
   output logic signed [COORD_W-1:0] o_x,
   output logic signed [COORD_W-1:0] o_y,
   output logic signed [ERR_W-1:0]   o_err
);

   logic signed [ERR_W:0]     w_e2;
   logic signed [ERR_W:0]     w_dx_e;
   logic signed [ERR_W:0]     w_dy_e;
   logic                      w_fx;
   logic                      w_fy;
   logic signed [COORD_W-1:0] w_sxv;
   logic signed [COORD_W-1:0] w_syv;
   logic signed [ERR_W-1:0]   w_add_x;
   logic signed [ERR_W-1:0]   w_add_y;

   always_comb begin
      w_e2    = {i_err, 1'b0};
      w_dx_e  = (ERR_W+1)'(i_dx);
      w_dy_e  = (ERR_W+1)'(i_dy);
      w_fx    = (w_e2 >= w_dy_e);
      w_fy    = (w_e2 <= w_dx_e);
      w_sxv   = i_sx_neg ? {COORD_W{1'b1}} : COORD_W'(1);
      w_syv   = i_sy_neg ? {COORD_W{1'b1}} : COORD_W'(1);
      w_add_x = w_fx ? i_dy : {ERR_W{1'b0}};
      w_add_y = w_fy ? i_dx : {ERR_W{1'b0}};
      o_x     = w_fx ? i_x + w_sxv : i_x;
      o_y     = w_fy ? i_y + w_syv : i_y;
      o_err   = i_err + w_add_x + w_add_y;
   end

endmodule

// File: rtl/line_rasterizer.sv
// Bresenham line engine driving a 1-bit framebuffer write port, one write per pixel.
// Optional build macro LINE_RASTER_CLIP_EN suppresses writes for off-screen pixels.
module line_rasterizer
   import gpu_raster_pkg::*;
(
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_stb,
   input  logic                      i_start,
   input  logic signed [COORD_W-1:0] i_x0,
   input  logic signed [COORD_W-1:0] i_y0,
   input  logic signed [COORD_W-1:0] i_x1,
   input  logic signed [COORD_W-1:0] i_y1,
   input  logic                      i_color,
   output logic                      o_busy,
   output logic                      o_done,
   output logic [ADDR_W-1:0]         o_fb_addr,
   output logic                      o_fb_data,
   output logic                      o_fb_we_n,
   output logic [COORD_W:0]          o_pix_count
);

   state_e                    r_state;
   logic signed [COORD_W-1:0] r_x, r_y, r_x1, r_y1;
   logic signed [ERR_W-1:0]   r_dx, r_dy, r_err;
   logic                      r_sx_neg, r_sy_neg, r_color;
   logic                      r_busy, r_done, r_fb_data, r_fb_we_n;
   logic [ADDR_W-1:0]         r_fb_addr;
   logic [COORD_W:0]          r_pix_count;

   logic signed [ERR_W-1:0]   w_dx_raw, w_dy_raw, w_adx, w_ady;
   logic signed [COORD_W-1:0] w_nx, w_ny;
   logic signed [ERR_W-1:0]   w_nerr;
   logic                      w_plot_we_n;

   assign w_dx_raw = ERR_W'(r_x1) - ERR_W'(r_x);
   assign w_dy_raw = ERR_W'(r_y1) - ERR_W'(r_y);
   assign w_adx    = w_dx_raw[ERR_W-1] ? -w_dx_raw : w_dx_raw;
   assign w_ady    = w_dy_raw[ERR_W-1] ? -w_dy_raw : w_dy_raw;

`ifdef LINE_RASTER_CLIP_EN
   localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_WIDTH);
   localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_HEIGHT);
   assign w_plot_we_n = r_x[COORD_W-1] || (r_x >= X_LIM) || r_y[COORD_W-1] || (r_y >= Y_LIM);
`else
   assign w_plot_we_n = 1'b0;
`endif

   line_raster_step u_step (
      .i_x      (r_x),
      .i_y      (r_y),
      .i_err    (r_err),
      .i_dx     (r_dx),
      .i_dy     (r_dy),
      .i_sx_neg (r_sx_neg),
      .i_sy_neg (r_sy_neg),
      .o_x      (w_nx),
      .o_y      (w_ny),
      .o_err    (w_nerr)
   );

   // Strobe and done default inactive every clock so each lasts one i_clk cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_x1        <= '0;
         r_y1        <= '0;
         r_dx        <= '0;
         r_dy        <= '0;
         r_err       <= '0;
         r_sx_neg    <= 1'b0;
         r_sy_neg    <= 1'b0;
         r_color     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_fb_addr   <= '0;
         r_fb_data   <= 1'b0;
         r_fb_we_n   <= 1'b1;
         r_pix_count <= '0;
      end else begin
         r_fb_we_n <= 1'b1;
         r_done    <= 1'b0;
         if (i_stb) begin
            case (r_state)
               IDLE: begin
                  if (i_start) begin
                     r_x         <= i_x0;
                     r_y         <= i_y0;
                     r_x1        <= i_x1;
                     r_y1        <= i_y1;
                     r_color     <= i_color;
                     r_busy      <= 1'b1;
                     r_pix_count <= '0;
                     r_state     <= SETUP;
                  end
               end
               SETUP: begin
                  r_dx     <= w_adx;
                  r_dy     <= -w_ady;
                  r_err    <= w_adx - w_ady;
                  r_sx_neg <= w_dx_raw[ERR_W-1];
                  r_sy_neg <= w_dy_raw[ERR_W-1];
                  r_state  <= PLOT;
               end
               PLOT: begin
                  r_fb_addr   <= pix_addr(r_x, r_y);
                  r_fb_data   <= r_color;
                  r_fb_we_n   <= w_plot_we_n;
                  r_pix_count <= r_pix_count + (COORD_W+1)'(1);
                  r_state     <= WRITE;
               end
               WRITE: begin
                  if (r_x == r_x1 && r_y == r_y1) begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_state <= STEP;
                  end
               end
               STEP: begin
                  r_x     <= w_nx;
                  r_y     <= w_ny;
                  r_err   <= w_nerr;
                  r_state <= PLOT;
               end
               DONE: begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_fb_addr   = r_fb_addr;
   assign o_fb_data   = r_fb_data;
   assign o_fb_we_n   = r_fb_we_n;
   assign o_pix_count = r_pix_count;

endmodule
